// File: rtl/ins_loader_pkg.sv
// Shared constants for the instruction loader: state encoding, widths, defaults.
package ins_loader_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned COUNT_W = 16;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned BYTE_W  = 8;

   localparam logic [STATE_W-1:0] IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] LOAD  = 2'd1;
   localparam logic [STATE_W-1:0] WRITE = 2'd2;
   localparam logic [STATE_W-1:0] DONE  = 2'd3;

   localparam logic [WORD_W-1:0] ENTRY_DEFAULT = 32'h80;
   localparam int unsigned       DEPTH_DEFAULT = 256;

   // A load request is accepted only for 1..depth words.
   function automatic logic countOk(input logic [COUNT_W-1:0] c, input int unsigned depth);
      return (c != '0) && (32'(c) <= depth);
   endfunction

endpackage

// File: rtl/ins_loader_packer.sv
// Big-endian byte packer: holds the three most recent bytes and a 2-bit byte index.
// word is the value the packed word would have once the current inByte is shifted in,
// so the top level can capture a complete word on the same edge as the 4th byte.
module byte_packer
   import ins_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              shiftEn,
   input  logic              clear,
   input  logic [BYTE_W-1:0] inByte,
   output logic [WORD_W-1:0] word,
   output logic              last
);

   logic [WORD_W-BYTE_W-1:0] shiftReg;
   logic [1:0]               byteIdx;

   // Shift accepted bytes in MSB-first; clear discards any partial word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shiftReg <= '0;
         byteIdx  <= '0;
      end else if (clear) begin
         shiftReg <= '0;
         byteIdx  <= '0;
      end else if (shiftEn) begin
         shiftReg <= {shiftReg[WORD_W-2*BYTE_W-1:0], inByte};
         byteIdx  <= byteIdx + 2'd1;
      end
   end

   assign word = {shiftReg, inByte};
   assign last = (byteIdx == 2'd3);

endmodule

// File: rtl/ins_loader.sv
// Streams a byte program into instruction memory as big-endian words starting at ENTRY,
// holding the CPU at its entry point (INT=1) until the load completes.
module ins_loader
   import ins_loader_pkg::*;
#(
   parameter logic [WORD_W-1:0] ENTRY       = ENTRY_DEFAULT,
   parameter int unsigned       DEPTH_WORDS = DEPTH_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] count,
   input  logic [BYTE_W-1:0]  inByte,
   input  logic               inValid,
   output logic               inReady,
   output logic [WORD_W-1:0]  memAddr,
   output logic [WORD_W-1:0]  memData,
   output logic               memWrite,
   output logic               INT,
   output logic               done,
   output logic               error
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] nextState;
   logic [COUNT_W-1:0] countLat;
   logic [COUNT_W-1:0] wordIdx;
   logic [WORD_W-1:0]  packWord;
   logic               packLast;

   logic startWindow;
   logic startOk;
   logic startAccept;
   logic accept;
   logic captureWord;

   logic nextInReady;
   logic nextMemWrite;
   logic nextDone;
   logic nextInt;
   logic nextError;

   assign startWindow = (state == IDLE) || (state == DONE);
   assign startOk     = countOk(count, DEPTH_WORDS);
   assign startAccept = startWindow && start && startOk;
   assign accept      = inValid && inReady;
   assign captureWord = (state == LOAD) && accept && packLast;

   byte_packer uPacker (
      .clk     (clk),
      .reset   (reset),
      .shiftEn (accept),
      .clear   (startAccept),
      .inByte  (inByte),
      .word    (packWord),
      .last    (packLast)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state logic.
   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: if (startAccept) nextState = LOAD;
         LOAD:       if (captureWord) nextState = WRITE;
         WRITE:      nextState = ((wordIdx + 16'd1) == countLat) ? DONE : LOAD;
         default:    nextState = IDLE;
      endcase
   end

   // Output decode from the upcoming state so registered outputs track the state exactly.
   always_comb begin
      nextInReady  = (nextState == LOAD);
      nextMemWrite = (nextState == WRITE);
      nextDone     = (nextState == DONE);
      nextInt      = (nextState != DONE);
      nextError    = startWindow && start && !startOk;
   end

   // Registered outputs; address and data only change when a word is captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inReady  <= 1'b0;
         memWrite <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         INT      <= 1'b1;
         memAddr  <= ENTRY;
         memData  <= '0;
      end else begin
         inReady  <= nextInReady;
         memWrite <= nextMemWrite;
         done     <= nextDone;
         error    <= nextError;
         INT      <= nextInt;
         if (captureWord) begin
            memAddr <= ENTRY + (32'(wordIdx) << 2);
            memData <= packWord;
         end
      end
   end

   // Word counter and latched program length.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         countLat <= '0;
         wordIdx  <= '0;
      end else if (startAccept) begin
         countLat <= count;
         wordIdx  <= '0;
      end else if (state == WRITE) begin
         wordIdx  <= wordIdx + 16'd1;
      end
   end

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: directed scenarios plus randomized loads,
// a write monitor, and a tiny fetch model that runs once INT falls.
`timescale 1ns/1ps
module tb_ins_loader;
   import ins_loader_pkg::*;

   localparam logic [31:0] entryPoint = ENTRY_DEFAULT;
   localparam int unsigned depthWords = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] count;
   logic [7:0]  inByte;
   logic        inValid;
   logic        inReady;
   logic [31:0] memAddr;
   logic [31:0] memData;
   logic        memWrite;
   logic        INT;
   logic        done;
   logic        error;

   int checks   = 0;
   int failures = 0;

   logic [31:0] wrAddrQ[$];
   logic [31:0] wrDataQ[$];
   logic [31:0] imem[logic [31:0]];
   int          readyInWrite = 0;
   logic [31:0] cpuPc;
   logic [31:0] fetchQ[$];
   logic        cpuTrace = 1'b0;

   ins_loader #(.ENTRY(entryPoint), .DEPTH_WORDS(depthWords)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .count    (count),
      .inByte   (inByte),
      .inValid  (inValid),
      .inReady  (inReady),
      .memAddr  (memAddr),
      .memData  (memData),
      .memWrite (memWrite),
      .INT      (INT),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   // Record every write into the memory image and flag inReady during a write.
   always @(negedge clk) begin
      if (memWrite === 1'b1) begin
         wrAddrQ.push_back(memAddr);
         wrDataQ.push_back(memData);
         imem[memAddr] = memData;
         if (inReady !== 1'b0) readyInWrite++;
      end
      if (cpuTrace && INT === 1'b0) fetchQ.push_back(cpuPc);
   end

   function automatic logic [31:0] fetchWord(input logic [31:0] pc);
      return imem.exists(pc) ? imem[pc] : 32'h0;
   endfunction

   // Minimal CPU: PC forced to entry while INT, otherwise sequential with MIPS j.
   always @(posedge clk) begin
      if (INT !== 1'b0)
         cpuPc <= entryPoint;
      else if (fetchWord(cpuPc) >> 26 == 32'd2)
         cpuPc <= {cpuPc[31:28], fetchWord(cpuPc) << 6 >> 4};
      else
         cpuPc <= cpuPc + 32'd4;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic doStart(input logic [15:0] c);
      start = 1'b1;
      count = c;
      tick();
      start = 1'b0;
      count = 16'($urandom);
   endtask

   // Present one byte after a random idle gap; wait (bounded) for inReady, then let it transfer.
   task automatic pushByte(input logic [7:0] b, input int maxGap);
      int gap;
      int waitCycles;
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      inValid = 1'b0;
      repeat (gap) tick();
      inByte  = b;
      inValid = 1'b1;
      waitCycles = 0;
      while (inReady !== 1'b1 && waitCycles < 50) begin
         tick();
         waitCycles++;
      end
      check("byteAccepted", 32'(inReady), 32'd1);
      if (inReady === 1'b1) tick();
      inValid = 1'b0;
      inByte  = 8'($urandom);
   endtask

   // Full load with reference expectations: word i lands at entry + 4*i with its big-endian value.
   task automatic loadProgram(input logic [31:0] words[$], input int maxGap);
      int n;
      logic [31:0] w;
      n = words.size();
      doStart(16'(n));
      wrAddrQ.delete();
      wrDataQ.delete();
      check("startInt", 32'(INT), 32'd1);
      check("startReady", 32'(inReady), 32'd1);
      check("startDone", 32'(done), 32'd0);
      check("startError", 32'(error), 32'd0);
      for (int i = 0; i < n; i++) begin
         w = words[i];
         for (int k = 3; k >= 0; k--) pushByte(8'(w >> (8 * k)), maxGap);
         check("wrStrobe", 32'(memWrite), 32'd1);
         check("wrAddr", memAddr, entryPoint + 32'(i) * 32'd4);
         check("wrData", memData, w);
      end
      tick();
      check("endWrite", 32'(memWrite), 32'd0);
      check("endDone", 32'(done), 32'd1);
      check("endInt", 32'(INT), 32'd0);
      check("endReady", 32'(inReady), 32'd0);
      check("wrCount", 32'(wrAddrQ.size()), 32'(n));
      for (int i = 0; i < n && i < wrAddrQ.size(); i++) begin
         check("logAddr", wrAddrQ[i], entryPoint + 32'(i) * 32'd4);
         check("logData", wrDataQ[i], words[i]);
      end
   endtask

   initial begin
      logic [31:0] prog[$];
      int n;

      reset   = 1'b1;
      start   = 1'b0;
      count   = '0;
      inValid = 1'b0;
      inByte  = '0;
      repeat (3) tick();
      check("rstReady", 32'(inReady), 32'd0);
      check("rstWrite", 32'(memWrite), 32'd0);
      check("rstDone", 32'(done), 32'd0);
      check("rstError", 32'(error), 32'd0);
      check("rstInt", 32'(INT), 32'd1);
      check("rstAddr", memAddr, entryPoint);
      check("rstData", memData, 32'h0);
      reset = 1'b0;
      tick();

      // Rejections from IDLE.
      doStart(16'd0);
      check("rej0Error", 32'(error), 32'd1);
      check("rej0Int", 32'(INT), 32'd1);
      check("rej0Ready", 32'(inReady), 32'd0);
      tick();
      check("rej0Pulse", 32'(error), 32'd0);
      doStart(16'd257);
      check("rej257Error", 32'(error), 32'd1);
      check("rej257Int", 32'(INT), 32'd1);
      check("rej257Done", 32'(done), 32'd0);
      inByte = 8'hAA;
      inValid = 1'b1;
      repeat (3) tick();
      inValid = 1'b0;
      check("rej257Pulse", 32'(error), 32'd0);
      check("rejReady", 32'(inReady), 32'd0);
      check("rejNoWrite", 32'(wrAddrQ.size()), 32'd0);

      // Reset in the middle of a word discards the partial bytes.
      doStart(16'd1);
      pushByte(8'h12, 0);
      pushByte(8'h34, 0);
      reset = 1'b1;
      #1;
      check("midRstInt", 32'(INT), 32'd1);
      check("midRstReady", 32'(inReady), 32'd0);
      check("midRstWrite", 32'(memWrite), 32'd0);
      check("midRstAddr", memAddr, entryPoint);
      tick();
      reset = 1'b0;
      tick();
      prog = '{32'h20080005};
      loadProgram(prog, 0);

      // Single word, back-to-back bytes.
      prog = '{32'h8C010004};
      loadProgram(prog, 0);

      // Rejections from DONE keep the CPU running.
      doStart(16'd0);
      check("rejDoneError", 32'(error), 32'd1);
      check("rejDoneDone", 32'(done), 32'd1);
      check("rejDoneInt", 32'(INT), 32'd0);
      tick();
      check("rejDonePulse", 32'(error), 32'd0);
      check("rejDoneStay", 32'(done), 32'd1);

      // Three words with random stalls, then a two-word reload.
      prog.delete();
      repeat (3) prog.push_back($urandom);
      loadProgram(prog, 3);
      prog.delete();
      repeat (2) prog.push_back($urandom);
      loadProgram(prog, 2);

      // Random lengths and gaps.
      for (int t = 0; t < 4; t++) begin
         n = int'($urandom_range(6, 1));
         prog.delete();
         repeat (n) prog.push_back($urandom);
         loadProgram(prog, int'($urandom_range(3, 0)));
      end

      // Maximum length.
      prog.delete();
      repeat (depthWords) prog.push_back($urandom);
      loadProgram(prog, 0);
      check("maxLastAddr", wrAddrQ[wrAddrQ.size() - 1], entryPoint + 32'h3FC);

      // End-to-end: program ending in a self-jump, CPU released at INT fall.
      prog = '{32'h20080005, 32'h21080001, 32'h08000022};
      doStart(16'd3);
      fetchQ.delete();
      cpuTrace = 1'b1;
      for (int i = 0; i < 3; i++)
         for (int k = 3; k >= 0; k--) pushByte(8'(prog[i] >> (8 * k)), 1);
      repeat (12) tick();
      cpuTrace = 1'b0;
      check("fetchCount", 32'(fetchQ.size() >= 4), 32'd1);
      if (fetchQ.size() >= 4) begin
         check("fetch0", fetchQ[0], 32'h80);
         check("fetch1", fetchQ[1], 32'h84);
         check("fetch2", fetchQ[2], 32'h88);
         check("fetchLoop", fetchQ[fetchQ.size() - 1], 32'h88);
      end

      check("readyInWrite", 32'(readyInWrite), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
